// File: rtl/block_cmp_seq.sv
// -----------------------------------------------------------------------------
// block_cmp_seq
//
// Sequencer for the Z80 block-compare instructions CPI, CPD, CPIR and CPDR.
// After a start pulse it fetches (HL) over a request/acknowledge read port.
// It then steers the shared ALU through three operations: the compare
// A - (HL), the HL increment or decrement, and the BC decrement. The
// repeating forms loop back to the read until a match is found, BC reaches
// zero, or an interrupt (break_req) is pending between iterations. Final HL,
// BC and F are held on the outputs for the core register file.
//
// The ALU belongs to this block only while busy=1. The core multiplexes the
// ALU inputs on busy. Every alu_* output is decoded from registered state
// only, so there is no combinational loop through the shared ALU.
//
// Memory read handshake: mem_rd is raised in S_READ and held until a cycle
// in which mem_ack=1 is sampled; mem_data is taken in that same cycle. An
// ack in the first S_READ cycle is legal. mem_addr is valid while mem_rd=1.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, dir, rep       start pulse (sampled in S_IDLE), HL direction,
//                         repeating form
//   break_req             interrupt pending, stops a repeat between iterations
//   a_reg, hl_in, bc_in,
//   flags_in              operands latched at start
//   mem_rd, mem_addr,
//   mem_ack, mem_data     read port
//   alu_mode, alu_op_a,
//   alu_op_b, alu_flags   shared ALU controls and operands
//   alu_data, alu_fout    shared ALU results
//   hl_out, bc_out,
//   flags_out             working/final register values
//   busy, done            activity flag and one-cycle completion pulse
//   rep_pending, rd_err   completion status, valid with done
//   dbg_state_o           current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module block_cmp_seq #(
  parameter int                        RD_TIMEOUT     = 255,
  parameter int                        ALU_MODE_WIDTH = 3,
  parameter logic [ALU_MODE_WIDTH-1:0] ALU_MODE_CPB   = ALU_MODE_WIDTH'(4),
  parameter logic [ALU_MODE_WIDTH-1:0] ALU_MODE_INC   = ALU_MODE_WIDTH'(1),
  parameter logic [ALU_MODE_WIDTH-1:0] ALU_MODE_DEC   = ALU_MODE_WIDTH'(2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      dir,
  input  logic                      rep,
  input  logic                      break_req,
  input  logic [7:0]                a_reg,
  input  logic [15:0]               hl_in,
  input  logic [15:0]               bc_in,
  input  logic [5:0]                flags_in,
  output logic                      mem_rd,
  output logic [15:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [7:0]                mem_data,
  output logic [ALU_MODE_WIDTH-1:0] alu_mode,
  output logic [15:0]               alu_op_a,
  output logic [15:0]               alu_op_b,
  output logic [5:0]                alu_flags,
  input  logic [15:0]               alu_data,
  input  logic [5:0]                alu_fout,
  output logic [15:0]               hl_out,
  output logic [15:0]               bc_out,
  output logic [5:0]                flags_out,
  output logic                      busy,
  output logic                      done,
  output logic                      rep_pending,
  output logic                      rd_err,
  output logic [2:0]                dbg_state_o
);

  // Flag bit positions inside the 6-bit F image.
  localparam int FLAG_IDX_C  = 0;
  localparam int FLAG_IDX_N  = 1;
  localparam int FLAG_IDX_PV = 2;
  localparam int FLAG_IDX_H  = 3;
  localparam int FLAG_IDX_Z  = 4;
  localparam int FLAG_IDX_S  = 5;

  localparam logic [15:0] TMO_LIMIT = 16'(RD_TIMEOUT);
  localparam bit          TMO_EN    = (RD_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CMP  = 3'd2,
    S_HL   = 3'd3,
    S_BC   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic        rep_q, rep_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  data_q, data_d;
  logic [5:0]  fin_q, fin_d;       // F as latched at start
  logic [15:0] hl_q, hl_d;
  logic [15:0] bc_q, bc_d;
  logic [5:0]  fout_q, fout_d;     // F presented on flags_out
  logic        s_q, s_d;           // compare results
  logic        z_q, z_d;
  logic        h_q, h_d;
  logic [15:0] tmo_q, tmo_d;       // cycles spent waiting in S_READ
  logic        rep_pend_q, rep_pend_d;
  logic        rd_err_q, rd_err_d;

  logic        bc_nz;
  logic        repeat_ok;

  // A repeat is wanted when no match was found and BC is still non-zero
  // after this iteration's decrement. The new BC is the ALU result in S_BC.
  assign bc_nz     = (alu_data != 16'h0000);
  assign repeat_ok = rep_q && !z_q && bc_nz;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rep_d      = rep_q;
    a_d        = a_q;
    data_d     = data_q;
    fin_d      = fin_q;
    hl_d       = hl_q;
    bc_d       = bc_q;
    fout_d     = fout_q;
    s_d        = s_q;
    z_d        = z_q;
    h_d        = h_q;
    tmo_d      = tmo_q;
    rep_pend_d = rep_pend_q;
    rd_err_d   = rd_err_q;

    mem_rd     = 1'b0;
    mem_addr   = 16'h0000;
    alu_mode   = ALU_MODE_CPB;
    alu_op_a   = 16'h0000;
    alu_op_b   = 16'h0000;
    alu_flags  = 6'h00;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          dir_d      = dir;
          rep_d      = rep;
          a_d        = a_reg;
          hl_d       = hl_in;
          bc_d       = bc_in;
          fin_d      = flags_in;
          fout_d     = flags_in;
          tmo_d      = 16'h0000;
          rep_pend_d = 1'b0;
          rd_err_d   = 1'b0;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        mem_rd    = 1'b1;
        mem_addr  = hl_q;
        alu_flags = fin_q;
        // An ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          data_d  = mem_data;
          state_d = S_CMP;
        end else if (TMO_EN && ((tmo_q + 16'd1) == TMO_LIMIT)) begin
          rd_err_d = 1'b1;
          fout_d   = fin_q;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_CMP: begin
        alu_mode  = ALU_MODE_CPB;
        alu_op_a  = {8'h00, a_q};
        alu_op_b  = {8'h00, data_q};
        alu_flags = fin_q;
        s_d       = alu_fout[FLAG_IDX_S];
        z_d       = alu_fout[FLAG_IDX_Z];
        h_d       = alu_fout[FLAG_IDX_H];
        state_d   = S_HL;
      end

      S_HL: begin
        alu_mode  = dir_q ? ALU_MODE_DEC : ALU_MODE_INC;
        alu_op_a  = hl_q;
        alu_flags = fin_q;
        hl_d      = alu_data;
        state_d   = S_BC;
      end

      S_BC: begin
        alu_mode  = ALU_MODE_DEC;
        alu_op_a  = bc_q;
        alu_flags = fin_q;
        bc_d      = alu_data;
        fout_d[FLAG_IDX_S]  = s_q;
        fout_d[FLAG_IDX_Z]  = z_q;
        fout_d[FLAG_IDX_H]  = h_q;
        fout_d[FLAG_IDX_PV] = bc_nz;
        fout_d[FLAG_IDX_N]  = 1'b1;
        fout_d[FLAG_IDX_C]  = fin_q[FLAG_IDX_C];
        if (repeat_ok && !break_req) begin
          tmo_d   = 16'h0000;
          state_d = S_READ;
        end else begin
          // Tell the core the repeat was cut short so it can rewind PC.
          rep_pend_d = repeat_ok;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      rep_q      <= 1'b0;
      a_q        <= 8'h00;
      data_q     <= 8'h00;
      fin_q      <= 6'h00;
      hl_q       <= 16'h0000;
      bc_q       <= 16'h0000;
      fout_q     <= 6'h00;
      s_q        <= 1'b0;
      z_q        <= 1'b0;
      h_q        <= 1'b0;
      tmo_q      <= 16'h0000;
      rep_pend_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      rep_q      <= rep_d;
      a_q        <= a_d;
      data_q     <= data_d;
      fin_q      <= fin_d;
      hl_q       <= hl_d;
      bc_q       <= bc_d;
      fout_q     <= fout_d;
      s_q        <= s_d;
      z_q        <= z_d;
      h_q        <= h_d;
      tmo_q      <= tmo_d;
      rep_pend_q <= rep_pend_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign hl_out      = hl_q;
  assign bc_out      = bc_q;
  assign flags_out   = fout_q;
  assign rep_pending = rep_pend_q;
  assign rd_err      = rd_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_block_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_block_cmp_seq
//
// Self-checking bench for block_cmp_seq. A behavioural ALU and a memory
// responder form the environment. The driver computes each instruction's
// outcome from the block-compare rules and pushes it into exp_q at issue.
// A monitor pops one entry per done pulse and compares the results.
// -----------------------------------------------------------------------------
module tb_block_cmp_seq;

  localparam int         TB_TMO = 4;
  localparam logic [2:0] M_CPB  = 3'd4;
  localparam logic [2:0] M_INC  = 3'd1;
  localparam logic [2:0] M_DEC  = 3'd2;

  localparam int FC = 0, FN = 1, FPV = 2, FH = 3, FZ = 4, FS = 5;

  // Memory behaviour: 0 = zero wait, 1 = random 0..3 wait states, 2 = never ack.
  localparam int MM_ZERO = 0, MM_RAND = 1, MM_NOACK = 2;

  typedef struct packed {
    logic [15:0] hl;
    logic [15:0] bc;
    logic [5:0]  fl;
    logic        rep_pend;
    logic        rd_err;
    logic [15:0] lat;      // 16'hFFFF: latency not checked
    logic [31:0] issue;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start, dir, rep, break_req;
  logic [7:0]  a_reg;
  logic [15:0] hl_in, bc_in;
  logic [5:0]  flags_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [2:0]  alu_mode;
  logic [15:0] alu_op_a, alu_op_b;
  logic [5:0]  alu_flags;
  logic [15:0] alu_data;
  logic [5:0]  alu_fout;
  logic [15:0] hl_out, bc_out;
  logic [5:0]  flags_out;
  logic        busy, done, rep_pending, rd_err;
  logic [2:0]  dbg_state;

  block_cmp_seq #(
    .RD_TIMEOUT(TB_TMO),
    .ALU_MODE_WIDTH(3),
    .ALU_MODE_CPB(M_CPB),
    .ALU_MODE_INC(M_INC),
    .ALU_MODE_DEC(M_DEC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .rep(rep),
    .break_req(break_req), .a_reg(a_reg), .hl_in(hl_in), .bc_in(bc_in),
    .flags_in(flags_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .alu_mode(alu_mode),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_flags(alu_flags),
    .alu_data(alu_data), .alu_fout(alu_fout), .hl_out(hl_out),
    .bc_out(bc_out), .flags_out(flags_out), .busy(busy), .done(done),
    .rep_pending(rep_pending), .rd_err(rd_err), .dbg_state_o(dbg_state)
  );

  // ---------------- ALU model ----------------
  logic [8:0] alu_diff;
  assign alu_diff = {1'b0, alu_op_a[7:0]} - {1'b0, alu_op_b[7:0]};

  always_comb begin
    alu_data = 16'h0000;
    alu_fout = 6'h00;
    case (alu_mode)
      M_CPB: begin
        alu_data     = {8'h00, alu_diff[7:0]};
        alu_fout[FS] = alu_diff[7];
        alu_fout[FZ] = (alu_diff[7:0] == 8'h00);
        alu_fout[FH] = (alu_op_a[3:0] < alu_op_b[3:0]);
        alu_fout[FN] = 1'b1;
        alu_fout[FC] = alu_diff[8];
      end
      // Junk flags on inc/dec: the sequencer must not pick them up.
      M_INC: begin alu_data = alu_op_a + 16'd1; alu_fout = 6'b101101; end
      M_DEC: begin alu_data = alu_op_a - 16'd1; alu_fout = 6'b011010; end
      default: begin alu_data = 16'hDEAD; alu_fout = 6'h3F; end
    endcase
  end

  // ---------------- memory responder ----------------
  logic [7:0] mem [0:65535];
  int mem_mode = MM_ZERO;
  int wait_left = 0;
  bit in_read = 1'b0;

  always @(negedge clk) begin
    mem_ack  = 1'b0;
    mem_data = 8'($urandom);
    if (mem_rd && !reset) begin
      if (!in_read) begin
        in_read   = 1'b1;
        wait_left = (mem_mode == MM_RAND) ? int'($urandom_range(0, 3)) : 0;
      end
      if (mem_mode != MM_NOACK && wait_left == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
        in_read  = 1'b0;
      end else if (wait_left > 0) begin
        wait_left = wait_left - 1;
      end
    end else begin
      in_read = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: apply the block-compare rules iteration by iteration.
  function automatic exp_t model(input logic [7:0] a, input logic [15:0] hl,
                                 input logic [15:0] bc, input logic [5:0] f,
                                 input logic d, input logic r, input logic brk,
                                 input int mm);
    exp_t e;
    logic [15:0] h, b;
    logic [7:0]  m, res;
    logic        s, z, hf, pv, cont;
    int          n;
    e     = '0;
    e.lat = 16'hFFFF;
    if (mm == MM_NOACK) begin
      e.hl = hl; e.bc = bc; e.fl = f; e.rd_err = 1'b1;
      e.lat = 16'(TB_TMO + 1);
      return e;
    end
    h = hl; b = bc; n = 0;
    s = 1'b0; z = 1'b0; hf = 1'b0; pv = 1'b0; cont = 1'b0;
    do begin
      m    = mem[h];
      res  = a - m;
      s    = res[7];
      z    = (res == 8'h00);
      hf   = (a[3:0] < m[3:0]);
      h    = d ? h - 16'd1 : h + 16'd1;
      b    = b - 16'd1;
      pv   = (b != 16'h0000);
      cont = r && !z && pv;
      n++;
    end while (cont && !brk && n < 70000);
    e.hl = h; e.bc = b;
    e.fl[FS] = s; e.fl[FZ] = z; e.fl[FH] = hf;
    e.fl[FPV] = pv; e.fl[FN] = 1'b1; e.fl[FC] = f[FC];
    e.rep_pend = cont && brk;
    if (mm == MM_ZERO) e.lat = 16'(5 + 4 * (n - 1));
    return e;
  endfunction

  // Monitor: one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending instruction (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_t'(exp_q.pop_front());
        chk("hl_out", 32'(hl_out), 32'(e.hl));
        chk("bc_out", 32'(bc_out), 32'(e.bc));
        chk("flags_out", 32'(flags_out), 32'(e.fl));
        chk("rep_pending", 32'(rep_pending), 32'(e.rep_pend));
        chk("rd_err", 32'(rd_err), 32'(e.rd_err));
        chk("busy_at_done", 32'(busy), 32'd1);
        if (e.lat != 16'hFFFF) chk("latency", 32'(cyc) - e.issue, 32'(e.lat));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 5000 cycles");
    end
  endtask

  task automatic scramble_inputs();
    dir      = 1'($urandom);
    rep      = 1'($urandom);
    a_reg    = 8'($urandom);
    hl_in    = 16'($urandom);
    bc_in    = 16'($urandom);
    flags_in = 6'($urandom);
  endtask

  task automatic do_instr(input logic [7:0] a, input logic [15:0] hl,
                          input logic [15:0] bc, input logic [5:0] f,
                          input logic d, input logic r, input logic brk,
                          input int mm, input bit poke);
    exp_t e;
    wait_idle();
    mem_mode = mm;
    e = model(a, hl, bc, f, d, r, brk, mm);
    e.issue = 32'(cyc);
    exp_q.push_back(EXP_W'(e));
    a_reg = a; hl_in = hl; bc_in = bc; flags_in = f;
    dir = d; rep = r; break_req = brk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  ra;
    logic [15:0] rhl, rbc;
    logic        rd, rr;
    int          k, dn;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; break_req = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_alu_mode", 32'(alu_mode), 32'(M_CPB));
    chk("rst_alu_op_a", 32'(alu_op_a), 32'd0);
    chk("rst_alu_op_b", 32'(alu_op_b), 32'd0);
    chk("rst_alu_flags", 32'(alu_flags), 32'd0);
    chk("rst_hl_out", 32'(hl_out), 32'd0);
    chk("rst_bc_out", 32'(bc_out), 32'd0);
    chk("rst_flags_out", 32'(flags_out), 32'd0);
    chk("rst_rep_pending", 32'(rep_pending), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    reset = 1'b0;

    // CPI match, with a second start while busy that must be ignored
    mem[16'h1000] = 8'h3C;
    do_instr(8'h3C, 16'h1000, 16'h0005, 6'b000001, 1'b0, 1'b0, 1'b0, MM_ZERO, 1'b1);

    // CPD with half borrow, BC runs out
    mem[16'h2000] = 8'h01;
    do_instr(8'h10, 16'h2000, 16'h0001, 6'b000000, 1'b1, 1'b0, 1'b0, MM_ZERO, 1'b0);

    // CPIR finding a match on the fourth byte
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h00;
    mem[16'h3002] = 8'h00; mem[16'h3003] = 8'hAA;
    do_instr(8'hAA, 16'h3000, 16'h0010, 6'b000000, 1'b0, 1'b1, 1'b0, MM_ZERO, 1'b0);

    // CPIR cut short by a pending interrupt
    do_instr(8'hAA, 16'h3000, 16'h0010, 6'b000001, 1'b0, 1'b1, 1'b1, MM_ZERO, 1'b0);

    // HL wraps upward, HL wraps downward
    do_instr(8'h00, 16'hFFFF, 16'h0003, 6'b000000, 1'b0, 1'b0, 1'b0, MM_ZERO, 1'b0);
    do_instr(8'h00, 16'h0000, 16'h0003, 6'b000001, 1'b1, 1'b0, 1'b0, MM_ZERO, 1'b0);

    // BC=0 at start: wraps to FFFF and the repeat carries on
    mem[16'h4000] = 8'h00; mem[16'h4001] = 8'h55;
    do_instr(8'h55, 16'h4000, 16'h0000, 6'b000000, 1'b0, 1'b1, 1'b0, MM_ZERO, 1'b0);

    // Read timeout
    do_instr(8'h12, 16'h5000, 16'h0007, 6'b101011, 1'b0, 1'b1, 1'b0, MM_NOACK, 1'b0);

    // Reset while in S_HL: no done, busy drops on the next cycle
    wait_idle();
    mem_mode = MM_ZERO;
    a_reg = 8'h11; hl_in = 16'h6000; bc_in = 16'h0009; flags_in = 6'h00;
    dir = 1'b0; rep = 1'b1; break_req = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hl_out", 32'(hl_out), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized instructions, back to back
    for (int i = 0; i < 60; i++) begin
      ra  = 8'($urandom);
      rhl = 16'($urandom);
      rd  = 1'($urandom);
      rr  = 1'($urandom);
      dn  = int'($urandom_range(0, 9));
      rbc = (dn == 0) ? 16'h0000 : (dn == 1) ? 16'h0001 : 16'($urandom_range(2, 20));
      if (rr && rbc == 16'h0000) rbc = 16'h0003;
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(0, 12));
        mem[rd ? rhl - 16'(k) : rhl + 16'(k)] = ra;
      end
      do_instr(ra, rhl, rbc, 6'($urandom), rd, rr,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 6) ? MM_ZERO : MM_RAND,
               ($urandom_range(0, 7) == 0));
    end

    // A trailing random timeout
    do_instr(8'h77, 16'($urandom), 16'h0004, 6'($urandom), 1'b1, 1'b0, 1'b0, MM_NOACK, 1'b0);

    // Drain
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_cmp_seq.md
Name: block_cmp_seq

Overview:
Sequencer for the Z80 block-compare instructions CPI, CPD, CPIR and CPDR. Once started, it fetches (HL) over a simple memory-read handshake. It then drives the shared ALU for three operations in turn: the compare, the HL increment/decrement and the BC decrement. It loops for the repeating forms and hands final HL, BC and flags back to the core register file. The block owns the ALU only while busy=1; the core multiplexes ALU inputs on busy.

Parameters:
RD_TIMEOUT, 255, max cycles in S_READ waiting for mem_ack before abort (0 = no timeout)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to S_IDLE
start  input  1  one-cycle start pulse; sampled only in S_IDLE
dir  input  1  0 = increment HL (CPI/CPIR), 1 = decrement HL (CPD/CPDR)
rep  input  1  1 = repeating form (CPIR/CPDR)
break_req  input  1  interrupt pending; stops a repeat between iterations
a_reg  input  8  accumulator
hl_in  input  16  HL at start
bc_in  input  16  BC at start
flags_in  input  6  F at start (FLAG_IDX_* layout)
mem_rd  output  1  read request, held until mem_ack
mem_addr  output  16  read address (= current HL)
mem_ack  input  1  read data valid this cycle
mem_data  input  8  read data
alu_mode  output  ALU_MODE_WIDTH  ALU mode select
alu_op_a  output  16  ALU operand A
alu_op_b  output  16  ALU operand B
alu_flags  output  6  ALU flags_in
alu_data  input  16  ALU data_out
alu_fout  input  6  ALU flags_out
hl_out  output  16  working/final HL
bc_out  output  16  working/final BC
flags_out  output  6  final F
busy  output  1  high in every state except S_IDLE
done  output  1  one-cycle completion pulse
rep_pending  output  1  valid with done: repeat cut short by break_req
rd_err  output  1  valid with done: read timeout abort

Behaviour:
- Reset values: S_IDLE; mem_rd=0, mem_addr=0, alu_mode=ALU_MODE_CPB, alu_op_a/b=0, alu_flags=0, hl_out=0, bc_out=0, flags_out=0, busy=0, done=0, rep_pending=0, rd_err=0; internal data and timeout registers = 0.
- Reset mid-operation: abandons the instruction immediately; no done pulse; mem_rd drops in the same cycle reset is sampled.
- States: S_IDLE, S_READ, S_CMP, S_HL, S_BC, S_DONE.
- S_IDLE: start=1 latches dir, rep, a_reg, hl_in, bc_in and flags_in; clears the timeout counter; next state is S_READ. start in any other state is ignored.
- S_READ: mem_rd=1, mem_addr=hl_out.
  - mem_ack=1: capture mem_data, go to S_CMP. Same-cycle ack is legal.
  - Counter reaches RD_TIMEOUT: rd_err=1, flags_out = latched flags, go to S_DONE.
- S_CMP: alu_mode=ALU_MODE_CPB, op_a={8'h00,A}, op_b={8'h00,data}. Register S, Z and H from alu_fout.
- S_HL: alu_mode = ALU_MODE_DEC if dir else ALU_MODE_INC, op_a=hl_out; hl_out <= alu_data (16-bit wrap: FFFF+1 = 0000, 0000-1 = FFFF).
- S_BC: alu_mode=ALU_MODE_DEC, op_a=bc_out; bc_out <= alu_data.
  - flags_out: S/Z/H from S_CMP, PV = (new BC != 0), N=1, C = latched C.
  - Next state is S_READ when rep=1, Z=0, new BC != 0 and break_req=0; otherwise S_DONE.
  - When the repeat condition holds but break_req=1: rep_pending=1, go to S_DONE.
- BC=0 at start: decrements to FFFF, PV=1, and the repeat continues (65536 iterations, matches Z80).
- S_DONE: done=1 for one cycle, busy=1; next state S_IDLE. hl_out, bc_out, flags_out, rep_pending and rd_err hold until the next start.
- Latency, zero-wait memory: start at cycle 0; S_READ=1, S_CMP=2, S_HL=3, S_BC=4, done at cycle 5. Each extra repeat iteration costs 4 cycles plus wait states.
- The ALU is driven only from registered state, so there is no combinational path from alu_* inputs to alu_* outputs.

Test Plan:
- CPI: A=3C, HL=1000, BC=0005, F.C=1, mem[1000]=3C, zero-wait -> done at cycle 5; HL=1001, BC=0004, Z=1, PV=1, N=1, C=1, H=0.
- CPD borrow: A=10, HL=2000, BC=0001, mem=01 -> HL=1FFF, BC=0000, Z=0, H=1, PV=0, S=0.
- CPIR: A=AA, HL=3000, BC=0010, mem[3003]=AA, other bytes 00 -> 4 iterations, done at cycle 17; HL=3004, BC=000C, Z=1, PV=1.
- CPIR with break_req raised during the first S_BC (A=AA, mem=00, BC=0010) -> done at cycle 5; rep_pending=1, HL=3001, BC=000F, PV=1.
- Wrap and errors: HL=FFFF, dir=0 -> HL=0000. RD_TIMEOUT=4 with mem_ack held low -> rd_err=1 and done one cycle after the timeout. Reset asserted in S_HL -> busy=0 next cycle, no done pulse.
- start pulsed again while busy -> ignored. An immediate restart on the cycle after done is accepted.
